// File: rtl/hilo_div_ctrl.sv
// Divide sequencer and HI/LO register pair for DIV/DIVU, MULT/MULTU results and MTHI/MTLO.
// Latency: divide result lands on hi/lo at edge DIV_CYCLES after the start edge; divide-by-zero lands on the start edge.
// Backpressure: busy stalls the pipeline combinationally from the issuing cycle through the last RUN cycle.
module hilo_div_ctrl #(
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_start,
  input  logic        div_sign,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign_o,
  input  logic [63:0] div_result,
  input  logic        mul_we,
  input  logic [63:0] mul_result,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     div_a_q, div_a_d;
  logic [31:0]     div_b_q, div_b_d;
  logic            sign_q, sign_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            done_q, done_d;

  // State, operand latches and HI/LO; reset abandons any divide in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state and write selection; in IDLE a divide beats a multiply, which beats the moves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (div_start) begin
          if (rt_data != 32'h0) begin
            div_a_d = rs_data;
            div_b_d = rt_data;
            sign_d  = div_sign;
            cnt_d   = CW'(DIV_CYCLES - 1);
            state_d = RUN;
          end else begin
            // Divide by zero never reaches the divider: fixed result, no RUN phase.
            hi_d   = rs_data;
            lo_d   = 32'hFFFF_FFFF;
            done_d = 1'b1;
          end
        end else if (mul_we) begin
          hi_d = mul_result[63:32];
          lo_d = mul_result[31:0];
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      RUN: begin
        // Operands stay frozen; all other writers are ignored while the pipe is stalled.
        if (cnt_q == '0) begin
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (div_start && (state_q == IDLE)) || (state_q == RUN);
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_sign_o = sign_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign done       = done_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl with a behavioural divider on the operand outputs.
// Latency: expected HI/LO queued at issue, popped when done is seen.
// Backpressure: every wait on busy is bounded by a cycle budget.
module tb_hilo_div_ctrl;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start, div_sign;
  logic [31:0] rs_data, rt_data;
  logic [31:0] div_a, div_b;
  logic        div_sign_o;
  logic [63:0] div_result;
  logic        mul_we;
  logic [63:0] mul_result;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  hilo_div_ctrl #(.DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .div_start(div_start), .div_sign(div_sign),
    .rs_data(rs_data), .rt_data(rt_data),
    .div_a(div_a), .div_b(div_b), .div_sign_o(div_sign_o),
    .div_result(div_result),
    .mul_we(mul_we), .mul_result(mul_result),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural divider: {remainder, quotient}, truncating toward zero.
  function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'h0) return 64'h0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  assign div_result = divide(div_a, div_b, div_sign_o);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide, follow it through busy, then pop the scoreboard on done.
  task automatic do_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_hl, input int exp_busy, input bit poke_mtlo);
    int n;
    logic [63:0] want;
    @(negedge clk);
    div_start = 1'b1;
    div_sign  = sgn;
    rs_data   = a;
    rt_data   = b;
    exp_q.push_back(exp_hl);
    #1 chk({tag, "_busy_start"}, {63'h0, busy}, 64'h1);
    @(negedge clk);
    div_start = 1'b0;
    mul_we    = 1'b0;
    mthi      = 1'b0;
    if (poke_mtlo) begin
      mtlo  = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    #1;
    n = 0;
    while (busy && n < 50) begin
      chk({tag, "_hold_a"}, {32'h0, div_a}, {32'h0, a});
      chk({tag, "_hold_b"}, {32'h0, div_b}, {32'h0, b});
      chk({tag, "_hold_sign"}, {63'h0, div_sign_o}, {63'h0, sgn});
      n++;
      @(negedge clk);
      #1;
    end
    mtlo = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(1 + n), 64'(exp_busy));
    chk({tag, "_done"}, {63'h0, done}, 64'h1);
    want = exp_q.pop_front();
    chk({tag, "_hilo"}, {hi, lo}, want);
    @(negedge clk);
    #1 chk({tag, "_done_clear"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    rst_n = 1'b0; div_start = 1'b0; div_sign = 1'b0; rs_data = '0; rt_data = '0;
    mul_we = 1'b0; mul_result = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_divab", {div_a, div_b}, 64'h0);
    chk("rst_ctl", {61'h0, div_sign_o, busy, done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1 signed -7/2
    do_div("t1", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DC + 1, 1'b0);
    // T2 unsigned
    do_div("t2", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, DC + 1, 1'b0);
    // T3 divide by zero
    do_div("t3", 1'b1, 32'h1234, 32'h0, {32'h0000_1234, 32'hFFFF_FFFF}, 1, 1'b0);

    // Divide by zero beats a simultaneous multiply write
    mul_we = 1'b1;
    mul_result = 64'h9999_8888_7777_6666;
    do_div("prio", 1'b0, 32'h55, 32'h0, {32'h0000_0055, 32'hFFFF_FFFF}, 1, 1'b0);

    // T4 moves, then multiply beats mthi
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    #1 chk("t4_mt", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    chk("t4_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    mul_we = 1'b1; mthi = 1'b1; mul_result = 64'h1111_2222_3333_4444; wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mul_we = 1'b0; mthi = 1'b0;
    #1 chk("t4_mul", {hi, lo}, 64'h1111_2222_3333_4444);
    chk("t4_done", {63'h0, done}, 64'h0);

    // T5 reset during RUN
    @(negedge clk);
    div_start = 1'b1; div_sign = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    div_start = 1'b0;
    #1 chk("t5_run", {63'h0, busy}, 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t5_hilo", {hi, lo}, 64'h0);
    chk("t5_busy", {63'h0, busy}, 64'h0);
    for (int i = 0; i < DC + 2; i++) begin
      chk("t5_no_done", {63'h0, done}, 64'h0);
      @(negedge clk);
      #1;
    end
    chk("t5_hilo_after", {hi, lo}, 64'h0);

    // T6 signed overflow with mtlo pulsed during RUN
    do_div("t6", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, DC + 1, 1'b1);
    chk("t6_lo_hold", {32'h0, lo}, {32'h0, 32'h8000_0000});

    chk("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
